// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: RAM status, machine word and the memory arbiter FSM states.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IGRANT = 2'd1,
    DGRANT = 2'd2
  } arb_state_t;

endpackage

// File: rtl/memory_arbiter.sv
// Arbitrates one shared RAM port between the icache and the dcache. Data wins by
// default, but an instruction request is served after STARVE_MAX back-to-back data grants.
module memory_arbiter
  import cpu_types_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic      CLK,
  input  logic      nRST,
  input  logic      iREN,
  input  word_t     iaddr,
  output logic      iwait,
  output word_t     iload,
  input  logic      dREN,
  input  logic      dWEN,
  input  word_t     daddr,
  input  word_t     dstore,
  output logic      dwait,
  output word_t     dload,
  output logic      ramREN,
  output logic      ramWEN,
  output word_t     ramaddr,
  output word_t     ramstore,
  input  word_t     ramload,
  input  ramstate_t ramstate,
  output logic      mem_err
);

  localparam int                CNT_W      = $clog2(STARVE_MAX) + 1;
  localparam logic [CNT_W-1:0]  STARVE_LIM = CNT_W'(STARVE_MAX);

  arb_state_t       state_q, state_d;
  logic [CNT_W-1:0] starve_q, starve_d;
  logic             mem_err_q, mem_err_d;
  logic             dreq;

  assign dreq    = dREN | dWEN;
  assign mem_err = mem_err_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values, independent of block ordering.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q   <= IDLE;
      starve_q  <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      starve_q  <= starve_d;
      mem_err_q <= mem_err_d;
    end
  end

  // NOTE: every output of this block is assigned a default first, so no path through
  // the case statement can leave a signal unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    starve_d  = starve_q;
    mem_err_d = mem_err_q;
    ramREN    = 1'b0;
    ramWEN    = 1'b0;
    ramaddr   = '0;
    ramstore  = '0;
    iwait     = iREN;
    dwait     = dreq;
    iload     = '0;
    dload     = '0;

    if (state_q != IDLE && ramstate == ERROR) mem_err_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (!iREN) starve_d = '0;
        if (dreq && (!iREN || starve_q < STARVE_LIM)) state_d = DGRANT;
        else if (iREN)                                 state_d = IGRANT;
      end

      DGRANT: begin
        iwait = 1'b1;
        dwait = 1'b1;
        if (!dreq) begin
          // Requester withdrew: release the RAM with strobes low and no completion.
          state_d = IDLE;
        end else begin
          ramaddr  = daddr;
          ramstore = dstore;
          ramWEN   = dWEN;
          ramREN   = dREN & ~dWEN;
          if (ramstate == ACCESS) begin
            dwait   = 1'b0;
            dload   = ramload;
            state_d = IDLE;
            if (iREN && starve_q < STARVE_LIM) starve_d = starve_q + CNT_W'(1);
          end
        end
      end

      IGRANT: begin
        iwait = 1'b1;
        dwait = 1'b1;
        if (!iREN) begin
          state_d = IDLE;
        end else begin
          ramaddr = iaddr;
          ramREN  = 1'b1;
          if (ramstate == ACCESS) begin
            iwait    = 1'b0;
            iload    = ramload;
            state_d  = IDLE;
            starve_d = '0;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter: drives the cache and RAM sides by hand and
// checks the combinational handshake outputs mid-cycle against hand-computed values.
module tb_memory_arbiter;
  import cpu_types_pkg::*;

  logic      CLK = 1'b0;
  logic      nRST;
  logic      iREN, dREN, dWEN;
  word_t     iaddr, daddr, dstore, ramload;
  ramstate_t ramstate;
  logic      iwait, dwait, ramREN, ramWEN, mem_err;
  word_t     iload, dload, ramaddr, ramstore;

  int tests = 0;
  int fails = 0;

  memory_arbiter #(.STARVE_MAX(4)) dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .iREN     (iREN),
    .iaddr    (iaddr),
    .iwait    (iwait),
    .iload    (iload),
    .dREN     (dREN),
    .dWEN     (dWEN),
    .daddr    (daddr),
    .dstore   (dstore),
    .dwait    (dwait),
    .dload    (dload),
    .ramREN   (ramREN),
    .ramWEN   (ramWEN),
    .ramaddr  (ramaddr),
    .ramstore (ramstore),
    .ramload  (ramload),
    .ramstate (ramstate),
    .mem_err  (mem_err)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    iREN     = 1'b0;
    dREN     = 1'b0;
    dWEN     = 1'b0;
    iaddr    = '0;
    daddr    = '0;
    dstore   = '0;
    ramload  = '0;
    ramstate = FREE;
  endtask

  initial begin
    nRST = 1'b0;
    clear_inputs();
    #1;
    check("rst_ramREN",   32'(ramREN),  32'd0);
    check("rst_ramWEN",   32'(ramWEN),  32'd0);
    check("rst_ramaddr",  ramaddr,      32'd0);
    check("rst_ramstore", ramstore,     32'd0);
    check("rst_mem_err",  32'(mem_err), 32'd0);
    repeat (2) @(posedge CLK);
    #3 nRST = 1'b1;
    tick();

    // Single instruction fetch, 2-cycle latency.
    iREN = 1'b1; iaddr = 32'h40;
    #1;
    check("i1_idle_iwait",  32'(iwait),  32'd1);
    check("i1_idle_ramREN", 32'(ramREN), 32'd0);
    check("i1_idle_iload",  iload,       32'd0);
    tick();
    ramstate = ACCESS; ramload = 32'h8C010004;
    #1;
    check("i1_grant_ramREN",  32'(ramREN), 32'd1);
    check("i1_grant_ramaddr", ramaddr,     32'h40);
    check("i1_grant_iwait",   32'(iwait),  32'd0);
    check("i1_grant_iload",   iload,       32'h8C010004);
    check("i1_grant_dwait",   32'(dwait),  32'd1);
    tick();
    clear_inputs();
    #1;
    check("i1_after_ramREN", 32'(ramREN), 32'd0);
    check("i1_after_iwait",  32'(iwait),  32'd0);
    tick();

    // Simultaneous requests: data first, instruction right after.
    iREN = 1'b1; iaddr = 32'h44; dREN = 1'b1; daddr = 32'h200;
    #1;
    check("both_idle_iwait", 32'(iwait), 32'd1);
    check("both_idle_dwait", 32'(dwait), 32'd1);
    tick();
    ramstate = ACCESS; ramload = 32'h11112222;
    #1;
    check("both_d_ramaddr", ramaddr,     32'h200);
    check("both_d_ramREN",  32'(ramREN), 32'd1);
    check("both_d_ramWEN",  32'(ramWEN), 32'd0);
    check("both_d_dwait",   32'(dwait),  32'd0);
    check("both_d_dload",   dload,       32'h11112222);
    check("both_d_iwait",   32'(iwait),  32'd1);
    check("both_d_iload",   iload,       32'd0);
    tick();
    dREN = 1'b0; ramstate = FREE;
    #1;
    check("both_idle2_ramREN", 32'(ramREN), 32'd0);
    check("both_idle2_iwait",  32'(iwait),  32'd1);
    tick();
    ramstate = ACCESS; ramload = 32'h33334444;
    #1;
    check("both_i_ramaddr", ramaddr,    32'h44);
    check("both_i_iwait",   32'(iwait), 32'd0);
    check("both_i_iload",   iload,      32'h33334444);
    tick();
    clear_inputs();
    tick();

    // Read+write together is a write.
    dREN = 1'b1; dWEN = 1'b1; daddr = 32'h100; dstore = 32'hDEADBEEF; ramstate = BUSY;
    tick();
    #1;
    check("wr_ramWEN",   32'(ramWEN), 32'd1);
    check("wr_ramREN",   32'(ramREN), 32'd0);
    check("wr_ramstore", ramstore,    32'hDEADBEEF);
    check("wr_ramaddr",  ramaddr,     32'h100);
    check("wr_busy_dwait", 32'(dwait), 32'd1);
    check("wr_busy_dload", dload,      32'd0);
    tick();
    ramstate = ACCESS;
    #1;
    check("wr_access_dwait", 32'(dwait), 32'd0);
    tick();
    clear_inputs();
    tick();

    // Instruction grant stalled by BUSY, then ERROR.
    iREN = 1'b1; iaddr = 32'h80; ramstate = BUSY;
    tick();
    for (int c = 0; c < 3; c++) begin
      #1;
      check("busy_ramREN",  32'(ramREN),  32'd1);
      check("busy_ramaddr", ramaddr,      32'h80);
      check("busy_iwait",   32'(iwait),   32'd1);
      check("busy_mem_err", 32'(mem_err), 32'd0);
      tick();
    end
    ramstate = ERROR;
    #1;
    check("err_iwait",  32'(iwait),  32'd1);
    check("err_ramREN", 32'(ramREN), 32'd1);
    tick();
    ramstate = BUSY;
    #1;
    check("err_mem_err_set",   32'(mem_err), 32'd1);
    check("err_grant_kept",    32'(ramREN),  32'd1);
    check("err_grant_ramaddr", ramaddr,      32'h80);
    tick();
    ramstate = ACCESS; ramload = 32'h0000ABCD;
    #1;
    check("err_then_access_iwait", 32'(iwait), 32'd0);
    tick();
    clear_inputs();
    #1;
    check("mem_err_sticky", 32'(mem_err), 32'd1);
    tick();

    // Granted requester withdraws before ACCESS.
    dREN = 1'b1; daddr = 32'h300; ramstate = BUSY;
    tick();
    #1;
    check("drop_grant_ramREN", 32'(ramREN), 32'd1);
    tick();
    dREN = 1'b0;
    #1;
    check("drop_cycle_ramREN",  32'(ramREN), 32'd0);
    check("drop_cycle_ramaddr", ramaddr,     32'd0);
    check("drop_cycle_dwait",   32'(dwait),  32'd1);
    tick();
    #1;
    check("drop_idle_ramREN", 32'(ramREN), 32'd0);
    check("drop_idle_dwait",  32'(dwait),  32'd0);
    tick();

    // Starvation: 4 data completions, 1 instruction completion, then data again.
    iREN = 1'b1; iaddr = 32'h600; dWEN = 1'b1; daddr = 32'h500;
    dstore = 32'h0BADF00D; ramstate = ACCESS; ramload = 32'h55556666;
    for (int k = 0; k < 6; k++) begin
      #1;
      check("starve_idle_strobes", 32'(ramREN | ramWEN), 32'd0);
      check("starve_idle_iwait",   32'(iwait),           32'd1);
      tick();
      #1;
      if (k == 4) begin
        check("starve_igrant_iwait",   32'(iwait),  32'd0);
        check("starve_igrant_dwait",   32'(dwait),  32'd1);
        check("starve_igrant_ramaddr", ramaddr,     32'h600);
        check("starve_igrant_ramREN",  32'(ramREN), 32'd1);
      end else begin
        check("starve_dgrant_dwait",   32'(dwait),  32'd0);
        check("starve_dgrant_iwait",   32'(iwait),  32'd1);
        check("starve_dgrant_ramWEN",  32'(ramWEN), 32'd1);
        check("starve_dgrant_ramaddr", ramaddr,     32'h500);
      end
      tick();
    end
    clear_inputs();
    tick();

    // Reset in the middle of a stalled data grant.
    dREN = 1'b1; daddr = 32'h700; ramstate = BUSY;
    tick();
    #1;
    check("rstmid_grant_ramREN", 32'(ramREN), 32'd1);
    #1 nRST = 1'b0;
    #1;
    check("rstmid_ramREN",  32'(ramREN),  32'd0);
    check("rstmid_ramaddr", ramaddr,      32'd0);
    check("rstmid_dwait",   32'(dwait),   32'd1);
    check("rstmid_mem_err", 32'(mem_err), 32'd0);
    ramstate = ACCESS;
    tick();
    #1;
    check("rstheld_dwait",  32'(dwait),  32'd1);
    check("rstheld_ramREN", 32'(ramREN), 32'd0);
    nRST = 1'b1;
    #1;
    check("postrst_idle_ramREN", 32'(ramREN), 32'd0);
    check("postrst_idle_dwait",  32'(dwait),  32'd1);
    tick();
    #1;
    check("postrst_grant_dwait", 32'(dwait), 32'd0);
    tick();
    clear_inputs();
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/memory_arbiter.md
MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 The block SHALL have parameter STARVE_MAX, default 4: max consecutive data grants while an instruction request waits.
REQ-002 The block SHALL have port CLK  in  1  system clock, rising-edge active.
REQ-003 The block SHALL have port nRST  in  1  asynchronous active-low reset.
REQ-004 The block SHALL have port iREN  in  1  icache read request.
REQ-005 The block SHALL have port iaddr  in  32  icache word address.
REQ-006 The block SHALL have port iwait  out  1  icache stall; low for exactly the completion cycle.
REQ-007 The block SHALL have port iload  out  32  instruction data, valid when iwait low.
REQ-008 The block SHALL have port dREN  in  1  dcache read request.
REQ-009 The block SHALL have port dWEN  in  1  dcache write request.
REQ-010 The block SHALL have port daddr  in  32  dcache word address.
REQ-011 The block SHALL have port dstore  in  32  dcache write data.
REQ-012 The block SHALL have port dwait  out  1  dcache stall; low for exactly the completion cycle.
REQ-013 The block SHALL have port dload  out  32  data-read result, valid when dwait low.
REQ-014 The block SHALL have port ramREN  out  1  RAM read strobe.
REQ-015 The block SHALL have port ramWEN  out  1  RAM write strobe.
REQ-016 The block SHALL have port ramaddr  out  32  RAM address.
REQ-017 The block SHALL have port ramstore  out  32  RAM write data.
REQ-018 The block SHALL have port ramload  in  32  RAM read data.
REQ-019 The block SHALL have port ramstate  in  ramstate_t  RAM status: FREE, BUSY, ACCESS, ERROR.
REQ-020 The block SHALL have port mem_err  out  1  sticky flag, set on any ERROR during a grant.

Function
REQ-021 FSM states SHALL be IDLE, IGRANT, DGRANT; grant decision registered at IDLE exit.
REQ-022 In IDLE, ram strobes SHALL be low, iwait = iREN, dwait = (dREN|dWEN).
REQ-023 In IDLE, the next state SHALL be:
  - DGRANT if a data request is pending and (iREN low or starve_cnt < STARVE_MAX);
  - otherwise IGRANT if iREN high;
  - otherwise IDLE.
REQ-024 In DGRANT, the block SHALL drive ramaddr=daddr, ramstore=dstore, ramWEN=dWEN, ramREN=dREN & ~dWEN.
REQ-025 In IGRANT, the block SHALL drive ramaddr=iaddr, ramREN=1, ramWEN=0, ramstore=0.
REQ-026 dWEN and dREN both high SHALL be treated as a write.
REQ-027 When ramstate==ACCESS in a grant state, the granted wait SHALL drop low combinationally that cycle; dload/iload=ramload; next state IDLE.
REQ-028 The non-granted requester's wait SHALL stay high throughout a grant.
REQ-029 Minimum latency SHALL be 2 cycles from request to completion (IDLE cycle + ACCESS cycle).
REQ-030 ramstate FREE or BUSY during a grant SHALL hold the state and all ram outputs stable.
REQ-031 ramstate ERROR during a grant SHALL set mem_err, keep wait high and keep the grant.
REQ-032 If the granted requester drops its request before ACCESS, the block SHALL return to IDLE next cycle, with strobes low that cycle and no completion.
REQ-033 starve_cnt (width clog2(STARVE_MAX)+1) SHALL behave as follows:
  - increment on each DGRANT completion while iREN high, saturating at STARVE_MAX;
  - clear on IGRANT completion or whenever iREN low in IDLE.
REQ-034 iload/dload SHALL be 0 when the corresponding wait is high.

Reset
REQ-035 nRST low SHALL asynchronously set:
  - state IDLE, starve_cnt 0, mem_err 0;
  - all ram outputs 0 (combinationally from IDLE).
REQ-036 Reset mid-grant SHALL abandon the transfer with no completion pulse; the first post-reset cycle is IDLE.

Structure
REQ-037 ramstate_t and word_t SHALL come from cpu_types_pkg; arb_state_t (IDLE/IGRANT/DGRANT) SHALL be added there.
REQ-038 The block SHALL be a single module: one registered FSM plus counter, with combinational output logic; no sub-module.

Verification
REQ-039 iREN=1, iaddr=0x40, ramstate ACCESS on first grant cycle, ramload=0x8C010004 -> iwait low in cycle 2, iload=0x8C010004.
REQ-040 iREN and dREN asserted together, starve_cnt=0 -> DGRANT first; IGRANT immediately after the data completion.
REQ-041 dWEN held continuously with iREN held, STARVE_MAX=4 -> 4 data completions, then 1 instruction completion, then data resumes.
REQ-042 dWEN=dREN=1, daddr=0x100, dstore=0xDEADBEEF -> ramWEN=1, ramREN=0, ramstore=0xDEADBEEF.
REQ-043 Granted IGRANT with ramstate BUSY for 3 cycles, then ERROR -> outputs stable, iwait high, mem_err=1 and stays 1.
REQ-044 nRST pulsed low during DGRANT (ramstate BUSY) -> strobes 0 immediately, no dwait-low pulse, FSM in IDLE.
